valu_lane_sequencer: RTL and testbench
======================================

Name: valu_lane_sequencer

Overview:
Sequences one shared scalar ALU (WIDTH-bit, 3-bit op select, N/Z/V/C flags) across the LANES elements of a vector operation.
- Accepts a whole vector op over a valid/ready handshake.
- Feeds one lane per cycle to the ALU and collects the lane results and flags into a result vector.
- Presents the result over a second valid/ready handshake.
- Sits in the Execute stage between the vector issue logic and the ALU instance.

Parameters:
WIDTH, 48, element/ALU data width in bits
LANES, 4, number of vector elements per operation (>=2)
IDX_W, $clog2(LANES), lane index width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  vector op offered
start_ready  output  1  sequencer can accept an op (high only in IDLE)
op_sel  input  3  ALU op for all lanes (000 add, 001 sub, 110 pass A, 111 pass B, others pass A)
vec_a  input  LANES*WIDTH  operand A; lane i = bits [i*WIDTH +: WIDTH]
vec_b  input  LANES*WIDTH  operand B; same packing
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_sel  output  3  to ALU sel
alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_sel)
alu_n, alu_z, alu_v, alu_c  input  1 each  ALU flags
res_valid  output  1  result vector available
res_ready  input  1  consumer accepts result
res_vec  output  LANES*WIDTH  result vector, same packing
res_n_mask  output  LANES  per-lane N flag
res_z_mask  output  LANES  per-lane Z flag
res_any_v  output  1  OR of V over processed lanes
res_any_c  output  1  OR of C over processed lanes

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: start_ready=0 during the reset cycle, then 1 in IDLE. res_valid=0. res_vec, all masks and res_any_v/c = 0. Lane index=0. Operand/op registers=0.
- IDLE:
  - start_ready=1.
  - On start_valid, capture vec_a, vec_b and op_sel.
  - Clear the result vector, masks and OR-flags; set idx=0; go to RUN.
- RUN:
  - alu_a/alu_b = captured lane idx; alu_sel = captured op.
  - At the clock edge, write alu_out into res_vec lane idx and alu_n/alu_z into mask bit idx; OR alu_v/alu_c into res_any_v/res_any_c.
  - If idx==LANES-1, go to DONE; otherwise idx+1.
- DONE:
  - res_valid=1. res_vec, masks and flags are held stable until the res_valid&&res_ready edge, then go to IDLE.
- Latency: res_valid rises exactly LANES cycles after the accept edge. Throughput: one op per LANES+2 cycles minimum.
- start_ready=0 in RUN and DONE; start_valid is ignored there, with no queuing.
- Outside RUN: alu_a, alu_b and alu_sel are driven 0.
- The sequencer does not interpret op_sel; unsupported codes pass straight to the ALU.
- Reset asserted in any state, including mid-RUN, aborts the op in the next cycle: IDLE, all outputs at reset values, partial results discarded.
- Inputs vec_a, vec_b and op_sel may change freely after the accept edge without affecting the op in flight.

Optional Feature:
VALU_LANE_MASK_EN
- With the macro defined:
  - Adds input start_mask [LANES], captured at accept.
  - RUN visits only enabled lanes, in ascending order, with no idle cycles for disabled lanes.
  - Disabled lanes write lane A (merge) into res_vec, leave their mask bits 0 and do not contribute to res_any_v/c.
  - Latency = popcount(start_mask).
  - An all-zero mask goes from IDLE directly to DONE, with res_valid asserted one cycle after accept.
- Without the macro: no start_mask port, and all lanes are processed.

Test Plan:
1. LANES=4, WIDTH=48. A={1,2,3,4}, B={10,20,30,40}, op 000 -> res_vec={11,22,33,44}, res_valid 4 cycles after accept, z_mask=0000, n_mask=0000, any_v=0.
2. A=B={5,5,5,5}, op 001 -> res_vec all 0, z_mask=1111, any_v=0.
3. Lane0 A=0x7FFF_FFFF_FFFF, B=1, op 000 (other lanes 0+0) -> lane0=0x8000_0000_0000, n_mask=0001, any_v=1, z_mask=1110.
4. op 111 with B={7,8,9,10} -> res_vec={7,8,9,10}. Hold res_ready=0 for 5 cycles with start_valid=1 -> res_valid and res_vec stable, start_ready=0, no second op accepted until the handshake edge.
5. Assert rst for 1 cycle while in RUN with idx=2 -> next cycle IDLE, res_valid=0, res_vec=0. start_ready=1 the cycle after rst deasserts; a new op then completes normally.
6. (VALU_LANE_MASK_EN) mask=0101, A={1,2,3,4}, B={1,1,1,1}, op 000 -> res_vec={2,2,4,4}, latency 2 cycles. mask=0000 -> res_valid 1 cycle after accept, res_vec=A.

Source files
------------

// File: rtl/valu_lane_sequencer.sv
// valu_lane_sequencer
// Time-multiplexes one shared scalar ALU across the LANES elements of a
// vector op: accept a whole op, feed one lane per cycle to the ALU, collect
// results and flags, then offer the assembled result vector.
//
// Optional build macro: VALU_LANE_MASK_EN
//   Adds a per-op lane-enable mask (start_mask). Only enabled lanes are sent
//   to the ALU, back to back. Disabled lanes return operand A unchanged and
//   contribute no flags. An all-zero mask skips RUN entirely.
module valu_lane_sequencer #(
  parameter int WIDTH = 48,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [2:0]             op_sel,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
`ifdef VALU_LANE_MASK_EN
  input  logic [LANES-1:0]       start_mask,
`endif
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_n,
  input  logic                   alu_z,
  input  logic                   alu_v,
  input  logic                   alu_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [LANES*WIDTH-1:0] res_vec,
  output logic [LANES-1:0]       res_n_mask,
  output logic [LANES-1:0]       res_z_mask,
  output logic                   res_any_v,
  output logic                   res_any_c
);

  // Lane index width is derived from LANES and not meant to be overridden.
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;
  logic [2:0]             op_q;
  logic [LANES*WIDTH-1:0] res_vec_q;
  logic [LANES-1:0]       res_n_q;
  logic [LANES-1:0]       res_z_q;
  logic                   any_v_q;
  logic                   any_c_q;
  logic                   res_valid_q;
  logic                   start_ready_q;

  // Lane-walk control: which lane comes after idx_q, and whether idx_q is last.
  logic [IDX_W-1:0]       next_idx_d;
  logic                   last_lane_d;

`ifdef VALU_LANE_MASK_EN
  logic [LANES-1:0]       mask_q;
  logic [IDX_W:0]         first_lane_d;  // {found, index}
  logic [IDX_W:0]         next_lane_d;   // {found, index}

  // Lowest set bit of m at or above position lo, returned as {found, index}.
  function automatic logic [IDX_W:0] lowest_set_from(input logic [LANES-1:0] m,
                                                     input int               lo);
    logic [IDX_W:0] r;
    r = '0;
    // Scan downward so the last hit, i.e. the lowest qualifying lane, wins.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  // Seed for the result vector: disabled lanes carry operand A, enabled lanes
  // start at zero and are overwritten as RUN visits them.
  function automatic logic [LANES*WIDTH-1:0] merge_disabled(
      input logic [LANES*WIDTH-1:0] a,
      input logic [LANES-1:0]       m);
    logic [LANES*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!m[i]) r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign first_lane_d = lowest_set_from(start_mask, 0);
  assign next_lane_d  = lowest_set_from(mask_q, int'(idx_q) + 1);
  assign next_idx_d   = next_lane_d[IDX_W-1:0];
  assign last_lane_d  = !next_lane_d[IDX_W];
`else
  assign next_idx_d   = idx_q + IDX_W'(1);
  assign last_lane_d  = (idx_q == IDX_W'(LANES - 1));
`endif

  // ALU drive: the captured lane under idx_q while running, quiet zeros otherwise.
  assign alu_a   = (state_q == S_RUN) ? a_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
  assign alu_b   = (state_q == S_RUN) ? b_q[int'(idx_q)*WIDTH +: WIDTH] : '0;
  assign alu_sel = (state_q == S_RUN) ? op_q : 3'b000;

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign res_vec     = res_vec_q;
  assign res_n_mask  = res_n_q;
  assign res_z_mask  = res_z_q;
  assign res_any_v   = any_v_q;
  assign res_any_c   = any_c_q;

  // Sequencer FSM with all handshake and result outputs registered.
  // NOTE: every register here is assigned with <= so each branch sees the
  // pre-edge values of state_q/idx_q; a blocking = would let later lines read
  // freshly updated state and break the one-lane-per-edge timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result and operand registers are plain flops, not a RAM, so
      // resetting them is cheap and guarantees an aborted op leaves no stale
      // lanes visible on res_vec.
      state_q       <= S_IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= 3'b000;
      res_vec_q     <= '0;
      res_n_q       <= '0;
      res_z_q       <= '0;
      any_v_q       <= 1'b0;
      any_c_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b0;
`ifdef VALU_LANE_MASK_EN
      mask_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          start_ready_q <= 1'b1;
          if (start_valid && start_ready_q) begin
            start_ready_q <= 1'b0;
            a_q           <= vec_a;
            b_q           <= vec_b;
            op_q          <= op_sel;
            res_n_q       <= '0;
            res_z_q       <= '0;
            any_v_q       <= 1'b0;
            any_c_q       <= 1'b0;
`ifdef VALU_LANE_MASK_EN
            mask_q        <= start_mask;
            res_vec_q     <= merge_disabled(vec_a, start_mask);
            idx_q         <= first_lane_d[IDX_W-1:0];
            if (first_lane_d[IDX_W]) begin
              state_q     <= S_RUN;
            end else begin
              // Nothing to compute: the merged A vector is the answer.
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
            end
`else
            res_vec_q     <= '0;
            idx_q         <= '0;
            state_q       <= S_RUN;
`endif
          end
        end

        S_RUN: begin
          res_vec_q[int'(idx_q)*WIDTH +: WIDTH] <= alu_out;
          res_n_q[idx_q]                        <= alu_n;
          res_z_q[idx_q]                        <= alu_z;
          any_v_q                               <= any_v_q | alu_v;
          any_c_q                               <= any_c_q | alu_c;
          if (last_lane_d) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end else begin
            idx_q       <= next_idx_d;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state_q       <= S_IDLE;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q       <= S_IDLE;
          res_valid_q   <= 1'b0;
          start_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_valu_lane_sequencer.sv
// Directed testbench for valu_lane_sequencer (WIDTH=48, LANES=4) with a small
// behavioural ALU attached to the alu_* ports.
module tb_valu_lane_sequencer;

  localparam int W = 48;
  localparam int L = 4;

  logic           clk;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [2:0]     op_sel;
  logic [L*W-1:0] vec_a;
  logic [L*W-1:0] vec_b;
`ifdef VALU_LANE_MASK_EN
  logic [L-1:0]   start_mask;
`endif
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_sel;
  logic [W-1:0]   alu_out;
  logic           alu_n;
  logic           alu_z;
  logic           alu_v;
  logic           alu_c;
  logic           res_valid;
  logic           res_ready;
  logic [L*W-1:0] res_vec;
  logic [L-1:0]   res_n_mask;
  logic [L-1:0]   res_z_mask;
  logic           res_any_v;
  logic           res_any_c;

  int n_checks = 0;
  int n_errors = 0;

  valu_lane_sequencer #(.WIDTH(W), .LANES(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sel      (op_sel),
    .vec_a       (vec_a),
    .vec_b       (vec_b),
`ifdef VALU_LANE_MASK_EN
    .start_mask  (start_mask),
`endif
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .alu_c       (alu_c),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_vec     (res_vec),
    .res_n_mask  (res_n_mask),
    .res_z_mask  (res_z_mask),
    .res_any_v   (res_any_v),
    .res_any_c   (res_any_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add, subtract (carry = no borrow), pass B, else pass A.
  always_comb begin
    logic [W:0] sum;
    sum   = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (alu_sel)
      3'b000: begin
        sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        alu_c = sum[W];
      end
      3'b001: begin
        sum   = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
        alu_v = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        alu_c = sum[W];
      end
      3'b111:  sum = {1'b0, alu_b};
      default: sum = {1'b0, alu_a};
    endcase
    alu_out = sum[W-1:0];
    alu_n   = alu_out[W-1];
    alu_z   = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [L*W-1:0] got, input logic [L*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*W-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                           input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Offer one op, scramble the inputs after the accept edge, and measure the
  // number of edges from accept until res_valid is seen.
  task automatic start_op(input string tag, input logic [2:0] op, input logic [L*W-1:0] a,
                          input logic [L*W-1:0] b, input int exp_lat);
    int lat;
    check({tag, "_start_ready"}, start_ready, 1);
    op_sel      = op;
    vec_a       = a;
    vec_b       = b;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    vec_a       = '1;
    vec_b       = '1;
    op_sel      = 3'b010;
    if (exp_lat > 0) check({tag, "_alu_sel"}, alu_sel, op);
    else             check({tag, "_alu_sel_idle"}, alu_sel, 0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic finish_op(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_ready_back"}, start_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*W-1:0] held;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    op_sel      = 3'b000;
    vec_a       = '0;
    vec_b       = '0;
`ifdef VALU_LANE_MASK_EN
    start_mask  = '1;
`endif
    tick();
    tick();
    check("rst_start_ready", start_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_vec", res_vec, 0);
    check("rst_masks", {res_n_mask, res_z_mask, res_any_v, res_any_c}, 0);
    check("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", start_ready, 1);

    // 1: lane-wise add
    start_op("t1", 3'b000, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), L);
    check("t1_vec", res_vec, pack4(11, 22, 33, 44));
    check("t1_z", res_z_mask, 4'b0000);
    check("t1_n", res_n_mask, 4'b0000);
    check("t1_vc", {res_any_v, res_any_c}, 2'b00);
    finish_op("t1");

    // 2: equal operands subtract to zero in every lane
    start_op("t2", 3'b001, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), L);
    check("t2_vec", res_vec, 0);
    check("t2_z", res_z_mask, 4'b1111);
    check("t2_n", res_n_mask, 4'b0000);
    check("t2_vc", {res_any_v, res_any_c}, 2'b01);
    finish_op("t2");

    // 3: signed overflow in lane 0 only
    start_op("t3", 3'b000, pack4(48'h7FFF_FFFF_FFFF, 0, 0, 0), pack4(1, 0, 0, 0), L);
    check("t3_vec", res_vec, pack4(48'h8000_0000_0000, 0, 0, 0));
    check("t3_n", res_n_mask, 4'b0001);
    check("t3_z", res_z_mask, 4'b1110);
    check("t3_vc", {res_any_v, res_any_c}, 2'b10);
    finish_op("t3");

    // 4: pass B, then stall the consumer while start_valid is pressed
    start_op("t4", 3'b111, pack4(1, 2, 3, 4), pack4(7, 8, 9, 10), L);
    held = pack4(7, 8, 9, 10);
    check("t4_vec", res_vec, held);
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_vec", res_vec, held);
      check("t4_hold_ready", start_ready, 0);
    end
    start_valid = 1'b0;
    finish_op("t4");

    // Unsupported op code goes straight to the ALU (reference ALU passes A)
    start_op("t_op3", 3'b011, pack4(21, 22, 23, 24), pack4(9, 9, 9, 9), L);
    check("t_op3_vec", res_vec, pack4(21, 22, 23, 24));
    finish_op("t_op3");

    // 5: reset while running at lane 2
    op_sel      = 3'b000;
    vec_a       = pack4(1, 2, 3, 4);
    vec_b       = pack4(10, 20, 30, 40);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    check("t5_alu_a_lane2", alu_a, 3);
    check("t5_alu_b_lane2", alu_b, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", res_valid, 0);
    check("t5_vec", res_vec, 0);
    check("t5_ready_low", start_ready, 0);
    check("t5_alu_idle", {alu_a, alu_sel}, 0);
    tick();
    check("t5_ready_high", start_ready, 1);
    start_op("t5b", 3'b000, pack4(100, 200, 300, 400), pack4(1, 2, 3, 4), L);
    check("t5b_vec", res_vec, pack4(101, 202, 303, 404));
    finish_op("t5b");

`ifdef VALU_LANE_MASK_EN
    // 6: lanes 0 and 2 enabled; lanes 1 and 3 merge A
    start_mask = 4'b0101;
    start_op("t6", 3'b000, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 2);
    check("t6_vec", res_vec, pack4(2, 2, 4, 4));
    finish_op("t6");
    start_mask = 4'b0000;
    start_op("t6z", 3'b000, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 0);
    check("t6z_vec", res_vec, pack4(1, 2, 3, 4));
    check("t6z_flags", {res_n_mask, res_z_mask, res_any_v, res_any_c}, 0);
    finish_op("t6z");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
